axil_mem_master: RTL and testbench

//   AXI-Lite master that turns single-beat CPU load/store requests into AXI-Lite transactions.

---
 rtl/axil_mem_master_if.sv | 29 ++
 rtl/axil_mem_master.sv | 201 ++++++++++++++++++++
 tb/tb_axil_mem_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mem_master_if.sv
// axil_mem_master_if: AXI-Lite bus bundle between the memory master and the RAM slave
//   master modport: drives AW/W/AR valid+payload and B/R ready
//   slave modport : drives AW/W/AR ready and B/R valid+payload
interface axil_mem_master_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_mem_master.sv
// axil_mem_master: turns single-beat CPU load/store requests into AXI-Lite transactions
//   clk, rst                 : clock, asynchronous active-high reset
//   req_*                    : CPU request (valid/ready, we, byte addr, store data)
//   resp_*                   : one-cycle completion pulse with load data and error flag
//   timeout_err              : sticky watchdog flag, cleared only by rst
//   m                        : AXI-Lite master port (one transaction outstanding)
module axil_mem_master #(
    parameter int TIMEOUT     = 256,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic                      timeout_err,
    axil_mem_master_if.master         m
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
    logic        err_q, err_d, timeout_q, timeout_d;
    logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [15:0] wd_q, wd_d, wd_next;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, wd_fire;

    assign aw_hs = awvalid_q && m.awready;
    assign w_hs  = wvalid_q && m.wready;
    assign b_hs  = bready_q && m.bvalid;
    assign ar_hs = arvalid_q && m.arready;
    assign r_hs  = rready_q && m.rvalid;

    // Any handshake restarts the watchdog window.
    assign wd_next = (aw_hs || w_hs || b_hs || ar_hs || r_hs) ? 16'd0 : wd_q + 16'd1;
    assign wd_fire = (TIMEOUT != 0) && (wd_next == 16'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        b_done_d     = b_done_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        wd_d         = wd_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    b_done_d    = 1'b0;
                    err_d       = 1'b0;
                    wd_d        = '0;
                    if (ALIGN_CHECK && req_addr[1:0] != 2'b00) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        rdata_d      = '0;
                    end else if (req_we) begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                wd_d      = wd_next;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                b_done_d  = b_done_q || b_hs;
                awvalid_d = awvalid_q && !aw_hs;
                wvalid_d  = wvalid_q && !w_hs;
                if (b_hs) err_d = m.bresp != 2'b00;
                // B may arrive in the same cycle as the last AW/W handshake.
                if (aw_done_d && w_done_d && b_done_d) begin
                    state_d      = RESP;
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_d;
                    rdata_d      = '0;
                end
            end
            READ: begin
                wd_d      = wd_next;
                arvalid_d = arvalid_q && !ar_hs;
                if (r_hs) begin
                    state_d      = RESP;
                    arvalid_d    = 1'b0;
                    rready_d     = 1'b0;
                    rdata_d      = m.rdata;
                    resp_valid_d = 1'b1;
                    resp_err_d   = m.rresp != 2'b00;
                end
            end
            RESP: begin
                state_d     = timeout_q ? HALT : IDLE;
                req_ready_d = !timeout_q;
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
        // Watchdog only fires if the transaction did not complete this cycle.
        if ((state_q == WRITE || state_q == READ) && state_d == state_q && wd_fire) begin
            state_d      = RESP;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
            timeout_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            b_done_q     <= b_done_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            wd_q         <= wd_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = resp_err_q;
    assign timeout_err = timeout_q;
    assign m.awaddr    = addr_q;
    assign m.awvalid   = awvalid_q;
    assign m.wdata     = wdata_q;
    assign m.wvalid    = wvalid_q;
    assign m.bready    = bready_q;
    assign m.araddr    = addr_q;
    assign m.arvalid   = arvalid_q;
    assign m.rready    = rready_q;
endmodule

// File: tb/tb_axil_mem_master.sv
// tb_axil_mem_master: randomized bench for axil_mem_master against a request-level model
module tb_axil_mem_master;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, timeout_err;
    logic [31:0] resp_rdata;

    axil_mem_master_if bus ();

    axil_mem_master #(.TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .timeout_err(timeout_err), .m(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave behaviour knobs: ready delays count cycles after valid; b/r delays count
    // cycles after the (last) address/data handshake, 0 meaning the same cycle.
    int       aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit       stall_ar = 1'b0;

    bit [31:0] ram [bit [31:0]];
    bit [31:0] model [bit [31:0]];

    initial begin
        bit aw_got, w_got, b_sent, ar_got, r_sent;
        int aw_c, w_c, b_c, ar_c, r_c;
        bit [31:0] s_addr, s_wdata, s_raddr;
        {aw_got, w_got, b_sent, ar_got, r_sent} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
        {s_addr, s_wdata, s_raddr} = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
        forever begin
            @(negedge clk);
            bus.awready = 1'b0;
            bus.wready  = 1'b0;
            bus.arready = 1'b0;
            if (rst || bus.bvalid) begin
                bus.bvalid = 1'b0;
                {aw_got, w_got, b_sent} = '0;
                {aw_c, w_c, b_c} = '0;
            end else begin
                if (bus.awvalid && !aw_got) begin
                    if (aw_c >= aw_dly) begin bus.awready = 1'b1; aw_got = 1'b1; s_addr = bus.awaddr; end
                    else aw_c++;
                end
                if (bus.wvalid && !w_got) begin
                    if (w_c >= w_dly) begin bus.wready = 1'b1; w_got = 1'b1; s_wdata = bus.wdata; end
                    else w_c++;
                end
                if (aw_got && w_got && !b_sent) begin
                    if (b_c >= b_dly) begin
                        bus.bvalid = 1'b1;
                        bus.bresp  = bresp_cfg;
                        b_sent     = 1'b1;
                        if (bresp_cfg == 2'b00) ram[s_addr] = s_wdata;
                    end else b_c++;
                end
            end
            if (rst || bus.rvalid) begin
                bus.rvalid = 1'b0;
                {ar_got, r_sent} = '0;
                {ar_c, r_c} = '0;
            end else begin
                if (bus.arvalid && !ar_got && !stall_ar) begin
                    if (ar_c >= ar_dly) begin bus.arready = 1'b1; ar_got = 1'b1; s_raddr = bus.araddr; end
                    else ar_c++;
                end
                if (ar_got && !r_sent) begin
                    if (r_c >= r_dly) begin
                        bus.rvalid = 1'b1;
                        bus.rresp  = rresp_cfg;
                        bus.rdata  = ram.exists(s_raddr) ? ram[s_raddr] : 32'h0;
                        r_sent     = 1'b1;
                    end else r_c++;
                end
            end
        end
    end

    int n_aw = 0, n_w = 0, n_ar = 0, n_arv = 0, n_aw_only = 0, n_w_only = 0;

    always @(posedge clk) begin
        if (bus.awvalid && bus.awready) n_aw <= n_aw + 1;
        if (bus.wvalid && bus.wready) n_w <= n_w + 1;
        if (bus.arvalid && bus.arready) n_ar <= n_ar + 1;
        if (bus.arvalid) n_arv <= n_arv + 1;
        if (bus.awvalid && !bus.wvalid) n_aw_only <= n_aw_only + 1;
        if (bus.wvalid && !bus.awvalid) n_w_only <= n_w_only + 1;
    end

    // lat counts cycles from the accept cycle to the resp_valid cycle (1 = next cycle).
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output bit err, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        if (resp_valid) begin
            @(posedge clk);
            #1;
            check("resp_pulse", resp_valid, 1'b0);
            check("rdata_hold", resp_rdata, rdata);
        end
    endtask

    task automatic run_one(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit mis, exp_err, er;
        logic [31:0] exp_rd, rd;
        int exp_lat, lat, aw0, w0, ar0, arv0, awo0, wo0;
        mis = addr[1:0] != 2'b00;
        exp_err = mis || (we ? bresp_cfg != 2'b00 : rresp_cfg != 2'b00);
        exp_rd = 32'h0;
        if (!mis && !we && model.exists(addr)) exp_rd = model[addr];
        if (mis) exp_lat = 1;
        else if (we) exp_lat = (aw_dly > w_dly ? aw_dly : w_dly) + b_dly + 2;
        else exp_lat = ar_dly + r_dly + 2;
        aw0 = n_aw; w0 = n_w; ar0 = n_ar; arv0 = n_arv; awo0 = n_aw_only; wo0 = n_w_only;
        do_req(we, addr, wdata, rd, er, lat);
        check("latency", lat, exp_lat);
        check("resp_err", er, exp_err);
        check("resp_rdata", rd, exp_rd);
        check("aw_count", n_aw - aw0, (!mis && we) ? 1 : 0);
        check("w_count", n_w - w0, (!mis && we) ? 1 : 0);
        check("ar_count", n_ar - ar0, (!mis && !we) ? 1 : 0);
        check("arvalid_cycles", n_arv - arv0, (!mis && !we) ? ar_dly + 1 : 0);
        check("aw_only_cycles", n_aw_only - awo0, (!mis && we && aw_dly > w_dly) ? aw_dly - w_dly : 0);
        check("w_only_cycles", n_w_only - wo0, (!mis && we && w_dly > aw_dly) ? w_dly - aw_dly : 0);
        if (!mis && we && bresp_cfg == 2'b00) model[addr] = wdata;
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        logic [31:0] rd;
        bit er;
        int lat, arv0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_awvalid", bus.awvalid, 1'b0);
        check("rst_wvalid", bus.wvalid, 1'b0);
        check("rst_bready", bus.bready, 1'b0);
        check("rst_arvalid", bus.arvalid, 1'b0);
        check("rst_rready", bus.rready, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_awaddr", bus.awaddr, 32'h0);

        set_dly(1, 1, 0, 1, 0);
        run_one(1'b1, 32'h10, 32'hDEADBEEF);
        run_one(1'b0, 32'h10, 32'h0);

        set_dly(2, 0, 0, 1, 0);
        run_one(1'b1, 32'h14, 32'hCAFEF00D);

        run_one(1'b0, 32'h6, 32'h0);
        run_one(1'b1, 32'h3, 32'h11111111);

        set_dly(0, 0, 0, 0, 1);
        run_one(1'b1, 32'h20, 32'h1234);
        rresp_cfg = 2'b10;
        run_one(1'b0, 32'h20, 32'h0);
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        run_one(1'b1, 32'h20, 32'h5555AAAA);
        bresp_cfg = 2'b00;
        run_one(1'b0, 32'h20, 32'h0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(0, 2));
            bresp_cfg = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            rresp_cfg = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
            a = {26'h0, 4'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_one(1'($urandom_range(0, 1)), a, $urandom);
        end
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b00;

        stall_ar = 1'b1;
        arv0 = n_arv;
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("to_latency", lat, TO + 1);
        check("to_resp_err", er, 1'b1);
        check("to_flag", timeout_err, 1'b1);
        check("to_arvalid_cycles", n_arv - arv0, TO);
        repeat (4) @(posedge clk);
        #1;
        check("halt_req_ready", req_ready, 1'b0);
        check("halt_arvalid", bus.arvalid, 1'b0);
        check("halt_resp_valid", resp_valid, 1'b0);
        check("halt_flag_sticky", timeout_err, 1'b1);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rec_timeout_clr", timeout_err, 1'b0);
        check("rec_req_ready", req_ready, 1'b1);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_arvalid_up", bus.arvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_arvalid", bus.arvalid, 1'b0);
        check("async_rready", bus.rready, 1'b0);
        check("async_req_ready", req_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_ar = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_arvalid", bus.arvalid, 1'b0);
        check("post_rst_resp_valid", resp_valid, 1'b0);

        set_dly(1, 1, 0, 1, 0);
        run_one(1'b0, 32'h10, 32'h0);
        run_one(1'b0, 32'h14, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
